seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//  Receive-side counterpart of the hex-to-7-segment encoder. Monitors multiplexed
//  display lines (digit anodes + segments), reconstructs the hex nibble per digit
//  and publishes a full DIGITS-wide word once every digit has been captured.
//  Used as an on-board self-check of display output and as a bench scoreboard.
// PARAMETERS
//  DIGITS         8   number of multiplexed digits / anode lines
//  STABLE_CYCLES  4   cycles {an,seg} must hold unchanged before capture (>=1)
// PORTS
//  clk          in   1         system clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  an           in   DIGITS    anode selects, active-low; exactly one low = valid
//  seg          in   7         segments {g,f,e,d,c,b,a}, active-low
//  clr          in   1         synchronous clear of seen mask and error flag
//  value        out  4*DIGITS  decoded word; digit i in value[4i+3:4i]
//  frame_valid  out  1         1-cycle pulse: value just updated with a full frame
//  digit_bad    out  DIGITS    per-digit invalid-pattern flags for the last frame
//  err          out  1         sticky: invalid pattern or multi-anode seen; clr clears
// BEHAVIOUR
//  - Reset: value=0, frame_valid=0, digit_bad=0, err=0, seen mask=0, state=IDLE.
//  - an/seg are registered once on input (1 cycle); all decisions use registered copy.
//  - Decode table (active-low seg -> nibble), exact inverse of the encoder:
//    0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
//    Any other pattern -> nibble 0, bad bit set, err set.
//  - FSM: IDLE   no anode low -> stay; one-hot -> SETTLE (cnt=1);
//                 >1 anode low -> set err, stay IDLE.
//         SETTLE {an,seg} unchanged -> cnt++; cnt==STABLE_CYCLES -> capture, go HOLD;
//                 change to one-hot -> restart cnt=1; otherwise -> IDLE.
//         HOLD   unchanged -> stay (no recapture); change -> as SETTLE/IDLE rules.
//  - STABLE_CYCLES=1: capture the first cycle a one-hot pattern is seen.
//  - Capture of digit i: shadow nibble[i] and shadow bad[i] written, seen[i]=1.
//    Recapturing an already-seen digit overwrites its shadow entry.
//  - When a capture makes seen all ones: next cycle value<=shadow, digit_bad<=shadow
//    bad, frame_valid=1 for exactly one cycle, seen cleared (same update edge).
//    Capture-to-frame_valid latency: 1 cycle; input-to-capture: 1+STABLE_CYCLES.
//  - clr and completing capture in same cycle: clr wins; no frame_valid, seen=0,
//    err=0; value/digit_bad keep previous frame.
//  - Counter saturates at STABLE_CYCLES; no wrap in HOLD however long the dwell.
//  - rst_n asserted mid-frame: all state to reset values immediately, no pulse.
// CONFIGURATION
//  SEG7_DP_EN defined: adds input dp (1, active-low decimal point) included in the
//   stability compare, and output dp_mask (DIGITS) updated with value on frame_valid;
//   dp never makes a pattern invalid.
//  SEG7_DP_EN undefined: no dp/dp_mask ports; behaviour otherwise identical.
// TESTING
//  1 Reset: rst_n=0 with random an/seg -> all outputs 0; release -> still 0, state IDLE.
//  2 Scan digits 7..0 = "1234ABCD", 6-cycle dwell each, STABLE_CYCLES=4 ->
//    one frame_valid pulse, value=32'h1234ABCD, digit_bad=0, err=0.
//  3 Digit 2 driven 7'h7F (blank) in a full scan -> value[11:8]=0, digit_bad=8'h04, err=1;
//    pulse clr -> err=0.
//  4 Glitch: seg changes after 2 of 4 stable cycles, then holds 4 -> only final pattern
//    captured; an=8'hFC (two low) -> err=1, no capture.
//  5 Last-digit capture coincident with clr -> no frame_valid, value unchanged; next
//    full scan -> pulse and new value.
//  6 Reset asserted after 5 of 8 digits -> outputs 0; fresh 8-digit scan required for pulse.

Source files
------------

// File: rtl/seg7_scan_decoder_if.sv
// Signal bundle between a multiplexed 7-segment display and its scan decoder.
// Defining SEG7_DP_EN adds the decimal-point input dp and the dp_mask output.
interface seg7_scan_decoder_if #(
    parameter int DIGITS = 8
);
    // No valid/ready handshake: an/seg/dp are free-running display lines, and
    // value/digit_bad/dp_mask may be consumed only in the cycle frame_valid is high.
    logic [DIGITS-1:0]   an;
    logic [6:0]          seg;
    logic                clr;
    logic [4*DIGITS-1:0] value;
    logic                frame_valid;
    logic [DIGITS-1:0]   digit_bad;
    logic                err;
    logic [1:0]          fsm_state;
`ifdef SEG7_DP_EN
    logic                dp;
    logic [DIGITS-1:0]   dp_mask;

    modport master (output an, seg, dp, clr,
                    input  value, frame_valid, digit_bad, err, dp_mask, fsm_state);
    modport slave  (input  an, seg, dp, clr,
                    output value, frame_valid, digit_bad, err, dp_mask, fsm_state);
`else
    modport master (output an, seg, clr,
                    input  value, frame_valid, digit_bad, err, fsm_state);
    modport slave  (input  an, seg, clr,
                    output value, frame_valid, digit_bad, err, fsm_state);
`endif
endinterface

// File: rtl/seg7_scan_decoder.sv
// Watches multiplexed 7-segment lines, decodes each stable digit and publishes a
// full frame once every digit has been captured. SEG7_DP_EN adds decimal-point capture.
module seg7_scan_decoder #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ZW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [DIGITS-1:0]   an_r, an_p;
    logic [6:0]          seg_r, seg_p;
    logic                changed, onehot, multi, capture;
    logic [ZW-1:0]       zeros;
    logic [IW-1:0]       idx;
    logic [4:0]          dec;
    logic [DIGITS-1:0]   seen, seen_n;
    logic                pend, pend_n;
    logic [4*DIGITS-1:0] shadow_val, value_r;
    logic [DIGITS-1:0]   shadow_bad, digit_bad_r;
    logic                frame_valid_r, err_r;

    // Returns {bad, nibble}; the table is the exact inverse of the hex encoder.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40: decode = 5'h00;  7'h79: decode = 5'h01;
            7'h24: decode = 5'h02;  7'h30: decode = 5'h03;
            7'h19: decode = 5'h04;  7'h12: decode = 5'h05;
            7'h02: decode = 5'h06;  7'h78: decode = 5'h07;
            7'h00: decode = 5'h08;  7'h10: decode = 5'h09;
            7'h08: decode = 5'h0A;  7'h03: decode = 5'h0B;
            7'h46: decode = 5'h0C;  7'h21: decode = 5'h0D;
            7'h06: decode = 5'h0E;  7'h0E: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    always_comb begin
        zeros = '0;
        idx   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_r[i]) begin
                zeros = zeros + 1'b1;
                idx   = IW'(i);
            end
        end
    end

    assign onehot = (zeros == ZW'(1));
    assign multi  = (zeros > ZW'(1));
    assign dec    = decode(seg_r);

`ifdef SEG7_DP_EN
    logic              dp_r, dp_p;
    logic [DIGITS-1:0] shadow_dp, dp_mask_r;
    assign changed     = {an_r, seg_r, dp_r} != {an_p, seg_p, dp_p};
    assign bus.dp_mask = dp_mask_r;

    // dp_mask bits are active-high: 1 means the decimal point was lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_r      <= 1'b1;
            dp_p      <= 1'b1;
            shadow_dp <= '0;
            dp_mask_r <= '0;
        end else begin
            dp_p <= dp_r;
            dp_r <= bus.dp;
            if (capture) shadow_dp[idx] <= ~dp_r;
            if (pend && !bus.clr) dp_mask_r <= shadow_dp;
        end
    end
`else
    assign changed = {an_r, seg_r} != {an_p, seg_p};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Any change of the registered lines restarts the dwell; HOLD only waits for a change.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        if (state == IDLE || changed) begin
            if (onehot) begin
                cnt_n = CW'(1);
                if (STABLE_CYCLES == 1) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end else begin
                    state_n = SETTLE;
                end
            end else begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        end else if (state == SETTLE) begin
            cnt_n = cnt + 1'b1;
            if (cnt_n == CW'(STABLE_CYCLES)) begin
                capture = 1'b1;
                state_n = HOLD;
            end
        end
    end

    // The frame is published one edge after the completing capture, clearing seen then.
    always_comb begin
        seen_n = pend ? '0 : seen;
        if (capture) seen_n[idx] = 1'b1;
        pend_n = capture && (&seen_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_r          <= '1;
            an_p          <= '1;
            seg_r         <= '1;
            seg_p         <= '1;
            seen          <= '0;
            pend          <= 1'b0;
            shadow_val    <= '0;
            shadow_bad    <= '0;
            value_r       <= '0;
            digit_bad_r   <= '0;
            frame_valid_r <= 1'b0;
            err_r         <= 1'b0;
        end else begin
            an_p  <= an_r;
            an_r  <= bus.an;
            seg_p <= seg_r;
            seg_r <= bus.seg;
            if (capture) begin
                shadow_val[{idx, 2'b00} +: 4] <= dec[3:0];
                shadow_bad[idx]               <= dec[4];
            end
            if (pend && !bus.clr) begin
                value_r     <= shadow_val;
                digit_bad_r <= shadow_bad;
            end
            frame_valid_r <= pend && !bus.clr;
            if (bus.clr) begin
                seen  <= '0;
                pend  <= 1'b0;
                err_r <= 1'b0;
            end else begin
                seen  <= seen_n;
                pend  <= pend_n;
                err_r <= err_r | multi | (capture & dec[4]);
            end
        end
    end

    assign bus.value       = value_r;
    assign bus.digit_bad   = digit_bad_r;
    assign bus.frame_valid = frame_valid_r;
    assign bus.err         = err_r;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed scans plus randomized scans,
// checked against a digit-level reference model and a frame scoreboard.
module tb_seg7_scan_decoder;
    localparam int DIGITS = 8;
    localparam int STABLE = 4;
    localparam int VW     = 4 * DIGITS;
    localparam int W      = VW + DIGITS;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_decoder_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [6:0] enc [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]      exp_q[$];
    logic [3:0]        m_nib [DIGITS];
    logic              m_bad [DIGITS];
    logic [DIGITS-1:0] m_seen;
    logic              m_err;
    logic [VW-1:0]     m_value;
    logic [DIGITS-1:0] m_digit_bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (enc[i] == s) return i;
        return -1;
    endfunction

    function automatic logic [DIGITS-1:0] an_of(input int d);
        logic [DIGITS-1:0] one;
        one = 1;
        return ~(one << d);
    endfunction

    // Scoreboard: every frame_valid pulse must match the oldest expected frame.
    always @(negedge clk) begin : monitor
        logic [W-1:0] e;
        if (rst_n === 1'b1 && bus.frame_valid === 1'b1) begin
            check("frame_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("frame_value", 64'(bus.value), 64'(e[VW-1:0]));
                check("frame_bad", 64'(bus.digit_bad), 64'(e[W-1:VW]));
            end
        end
    end

    task automatic model_reset();
        m_seen      = '0;
        m_err       = 1'b0;
        m_value     = '0;
        m_digit_bad = '0;
        for (int i = 0; i < DIGITS; i++) begin
            m_nib[i] = '0;
            m_bad[i] = 1'b0;
        end
    endtask

    // A one-hot pattern held STABLE cycles or more is one capture; clr_hit asserts
    // clr in exactly the cycle that capture lands.
    task automatic step(input logic [DIGITS-1:0] a, input logic [6:0] s, input int dwell,
                        input bit clr_hit);
        int zeros, d, n;
        logic [VW-1:0] v;
        logic [DIGITS-1:0] b;
        bus.an  = a;
        bus.seg = s;
        zeros = 0;
        d     = 0;
        for (int i = 0; i < DIGITS; i++) if (!a[i]) begin zeros++; d = i; end
        if (zeros > 1) m_err = 1'b1;
        for (int c = 1; c <= dwell; c++) begin
            @(negedge clk);
            bus.clr = (clr_hit && c == STABLE);
            if (zeros == 1 && c == STABLE) begin
                if (clr_hit) begin
                    m_seen = '0;
                    m_err  = 1'b0;
                end else begin
                    n = lookup(s);
                    m_nib[d] = (n < 0) ? 4'h0 : 4'(n);
                    m_bad[d] = (n < 0);
                    if (n < 0) m_err = 1'b1;
                    m_seen[d] = 1'b1;
                    if (&m_seen) begin
                        for (int i = 0; i < DIGITS; i++) begin
                            v[4*i +: 4] = m_nib[i];
                            b[i]        = m_bad[i];
                        end
                        exp_q.push_back({b, v});
                        m_value     = v;
                        m_digit_bad = b;
                        m_seen      = '0;
                    end
                end
            end
        end
        bus.clr = 1'b0;
    endtask

    task automatic idle(input int n);
        step('1, 7'h7F, n, 1'b0);
    endtask

    task automatic scan_word(input logic [VW-1:0] w, input int dwell, input int bad_digit);
        for (int i = DIGITS - 1; i >= 0; i--)
            step(an_of(i), (i == bad_digit) ? 7'h7F : enc[w[4*i +: 4]], dwell, 1'b0);
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        m_seen  = '0;
        m_err   = 1'b0;
    endtask

    task automatic end_checks(input string tag);
        idle(4);
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_value"}, 64'(bus.value), 64'(m_value));
        check({tag, "_bad"}, 64'(bus.digit_bad), 64'(m_digit_bad));
        check({tag, "_err"}, 64'(bus.err), 64'(m_err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_value"}, 64'(bus.value), 64'd0);
        check({tag, "_fv"}, 64'(bus.frame_valid), 64'd0);
        check({tag, "_bad"}, 64'(bus.digit_bad), 64'd0);
        check({tag, "_err"}, 64'(bus.err), 64'd0);
    endtask

    initial begin
        int order [DIGITS];
        int t, g, n;
        logic [6:0] s, gs;
        // Reset with random lines, then release onto an idle display.
        rst_n   = 1'b0;
        bus.clr = 1'b0;
        bus.an  = DIGITS'($urandom);
        bus.seg = 7'($urandom);
`ifdef SEG7_DP_EN
        bus.dp  = 1'b1;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_zero("rst_hold");
        bus.an  = '1;
        bus.seg = 7'h7F;
        rst_n   = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("rst_rel");
        check("rst_state", 64'(bus.fsm_state), 64'd0);

        // Clean scan of 1234ABCD.
        scan_word(32'h1234ABCD, 6, -1);
        end_checks("scan");

        // Blank pattern on digit 2, then clr.
        scan_word(32'h5678_9EF0, 6, 2);
        end_checks("blank");
        pulse_clr();
        @(negedge clk);
        check("blank_clr_err", 64'(bus.err), 64'd0);

        // Glitches and boundary dwell, then a two-anode pattern.
        for (int i = DIGITS - 1; i >= 3; i--) step(an_of(i), enc[i], 6, 1'b0);
        step(an_of(2), enc[5], 2, 1'b0);
        step(an_of(2), enc[9], STABLE, 1'b0);
        step(an_of(1), enc[3], STABLE - 1, 1'b0);
        step(an_of(1), enc[4], STABLE, 1'b0);
        step(an_of(0), enc[12], 6, 1'b0);
        end_checks("glitch");
        step(8'hFC, enc[1], 6, 1'b0);
        end_checks("multi");
        pulse_clr();

        // Completing capture coincides with clr; the next full scan publishes.
        for (int i = DIGITS - 1; i >= 1; i--) step(an_of(i), enc[15 - i], 6, 1'b0);
        step(an_of(0), enc[7], 6, 1'b1);
        end_checks("clr_hit");
        scan_word(32'hFEDC_0123, 6, -1);
        end_checks("after_clr");

        // Reset mid-frame; a partial follow-up scan must not publish.
        for (int i = DIGITS - 1; i >= 3; i--) step(an_of(i), enc[i + 2], 6, 1'b0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("midrst_hold");
        bus.an = '1;
        bus.seg = 7'h7F;
        rst_n = 1'b1;
        idle(2);
        for (int i = 2; i >= 0; i--) step(an_of(i), enc[i], 6, 1'b0);
        end_checks("midrst_partial");
        scan_word(32'hA5A5_3C3C, 6, -1);
        end_checks("midrst_full");

        // Randomized scans: random order, values, dwells, glitches, bad and multi-anode patterns.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < DIGITS; i++) order[i] = i;
            for (int i = DIGITS - 1; i > 0; i--) begin
                g = $urandom_range(0, i);
                t = order[i]; order[i] = order[g]; order[g] = t;
            end
            for (int k = 0; k < DIGITS; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    do s = 7'($urandom_range(0, 127)); while (lookup(s) >= 0);
                end else begin
                    s = enc[$urandom_range(0, 15)];
                end
                if ($urandom_range(0, 3) == 0) begin
                    do gs = enc[$urandom_range(0, 15)]; while (gs == s);
                    step(an_of(order[k]), gs, $urandom_range(1, STABLE - 1), 1'b0);
                end
                n = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(STABLE, STABLE + 5);
                step(an_of(order[k]), s, n, 1'b0);
                if (k == 3 && $urandom_range(0, 1) == 1)
                    step(an_of(order[0]), enc[$urandom_range(0, 15)], STABLE + 1, 1'b0);
                if ($urandom_range(0, 9) == 0) step(8'h3F, enc[0], 2, 1'b0);
            end
            end_checks("rand");
            if (r % 2 == 1) pulse_clr();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
